wb_rr_arbiter_ctrl: RTL and testbench

//  Arbitration controller sharing one wishbone slave port between N_REQ masters.
//  - Grants bus tenure round-robin.
//  - Holds each grant for the whole CYC tenure.
//  - Runs a per-tenure bus-timeout watchdog that synthesises ERR to a master whose

---
 rtl/wb_rr_arbiter_ctrl.sv | 156 +++++++++++++++
 tb/tb_wb_rr_arbiter_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_rr_arbiter_ctrl                                           |
// | Description : Round-robin wishbone tenure arbiter with bus-timeout watchdog |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_rr_arbiter_ctrl #(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         cyc,
    input  logic [N_REQ-1:0]         stb,
    input  logic                     s_ack,
    input  logic                     s_err,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     gnt_valid,
    output logic                     to_err,
    output logic                     slv_mask
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] c_tout_thr = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [ID_W-1:0]  c_last_rst = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TOUT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [ID_W-1:0]   r_gnt_id, w_gnt_id_nxt;
    logic [ID_W-1:0]   r_last_id, w_last_id_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_gnt_valid;
    logic              r_to_err, w_to_err_nxt;
    logic              r_slv_mask, w_slv_mask_nxt;

    logic [N_REQ-1:0]  w_req;
    logic [ID_W:0]     w_pick;

    // Scans from farthest to nearest so the last hit is the first requester after last_id.
    function automatic logic [ID_W:0] f_rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [ID_W-1:0]  last);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last) + k) % N_REQ);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_req  = cyc & stb;
    assign w_pick = f_rr_pick(w_req, r_last_id);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_last_id   <= c_last_rst;
            r_cnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_to_err    <= 1'b0;
            r_slv_mask  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_last_id   <= w_last_id_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt_valid <= |w_gnt_nxt;
            r_to_err    <= w_to_err_nxt;
            r_slv_mask  <= w_slv_mask_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_gnt_id_nxt   = r_gnt_id;
        w_last_id_nxt  = r_last_id;
        w_cnt_nxt      = r_cnt;
        w_to_err_nxt   = 1'b0;
        w_slv_mask_nxt = r_slv_mask;

        case (r_state)
            ST_IDLE: begin
                if (w_pick[ID_W]) begin
                    w_gnt_nxt                   = '0;
                    w_gnt_nxt[w_pick[ID_W-1:0]] = 1'b1;
                    w_gnt_id_nxt                = w_pick[ID_W-1:0];
                    w_last_id_nxt               = w_pick[ID_W-1:0];
                    w_cnt_nxt                   = '0;
                    w_state_nxt                 = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Release beats a response, which beats the timeout threshold.
                if (!cyc[r_gnt_id]) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (s_ack || s_err || !stb[r_gnt_id]) begin
                    w_cnt_nxt = '0;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == c_tout_thr)) begin
                    w_to_err_nxt   = 1'b1;
                    w_slv_mask_nxt = 1'b1;
                    w_state_nxt    = ST_TOUT;
                end else if (r_cnt != c_cnt_max) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_TOUT: begin
                if (!cyc[r_gnt_id]) begin
                    w_gnt_nxt      = '0;
                    w_slv_mask_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!cyc[r_gnt_id]) begin
                    w_gnt_nxt      = '0;
                    w_slv_mask_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_gnt_nxt      = '0;
                w_slv_mask_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign to_err    = r_to_err;
    assign slv_mask  = r_slv_mask;

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_rr_arbiter_ctrl                                        |
// | Description : Scoreboard bench for wb_rr_arbiter_ctrl (N_REQ=2, timeout 8) |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wb_rr_arbiter_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       s_ack;
    logic       s_err;
    logic [1:0] gnt;
    logic [0:0] gnt_id;
    logic       gnt_valid;
    logic       to_err;
    logic       slv_mask;

    wb_rr_arbiter_ctrl #(
        .N_REQ          (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cyc       (cyc),
        .stb       (stb),
        .s_ack     (s_ack),
        .s_err     (s_err),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .to_err    (to_err),
        .slv_mask  (slv_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {gnt, gnt_id, gnt_valid, to_err, slv_mask}.
    logic [5:0] obs;
    assign obs = {gnt, gnt_id, gnt_valid, to_err, slv_mask};

    logic [5:0] sb[$];
    logic [5:0] exp_v;
    int         n_chk  = 0;
    int         n_fail = 0;

    // Reference model state (0 IDLE, 1 GRANT, 2 TOUT, 3 DRAIN).
    int         m_state = 0;
    logic [1:0] m_gnt   = 2'b00;
    logic       m_id    = 1'b0;
    logic       m_last  = 1'b1;
    int         m_cnt   = 0;
    logic       m_to    = 1'b0;
    logic       m_mask  = 1'b0;

    task automatic model_step(input logic r, input logic [1:0] c, input logic [1:0] s,
                              input logic a, input logic e);
        logic [1:0] req;
        logic       p;
        if (r) begin
            m_state = 0; m_gnt = 2'b00; m_id = 1'b0; m_last = 1'b1;
            m_cnt = 0; m_to = 1'b0; m_mask = 1'b0;
        end else begin
            m_to = 1'b0;
            case (m_state)
                0: begin
                    req = c & s;
                    if (req != 2'b00) begin
                        p = ~m_last;
                        if (!req[p]) p = ~p;
                        m_gnt = 2'b00; m_gnt[p] = 1'b1;
                        m_id = p; m_last = p; m_cnt = 0; m_state = 1;
                    end
                end
                1: begin
                    if (!c[m_id]) begin
                        m_gnt = 2'b00; m_state = 0;
                    end else if (a || e || !s[m_id]) begin
                        m_cnt = 0;
                    end else if (m_cnt == 7) begin
                        m_to = 1'b1; m_mask = 1'b1; m_state = 2;
                    end else begin
                        m_cnt++;
                    end
                end
                2: begin
                    if (!c[m_id]) begin
                        m_gnt = 2'b00; m_mask = 1'b0; m_state = 0;
                    end else begin
                        m_state = 3;
                    end
                end
                default: begin
                    if (!c[m_id]) begin
                        m_gnt = 2'b00; m_mask = 1'b0; m_state = 0;
                    end
                end
            endcase
        end
    endtask

    // Drives one cycle of stimulus, queues the predicted outputs, and waits past the edge.
    task automatic tick(input logic r, input logic [1:0] c, input logic [1:0] s,
                        input logic a, input logic e);
        rst = r; cyc = c; stb = s; s_ack = a; s_err = e;
        model_step(r, c, s, a, e);
        sb.push_back({m_gnt, m_id, |m_gnt, m_to, m_mask});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_sb: got %b expected %b", obs, exp_v);
            end
            n_chk++;
            if (obs !== 6'b000000) begin
                n_fail++;
                $display("FAIL reset_zero: got %b expected %b", obs, 6'b000000);
            end
        end
    endtask

    task automatic test_basic_grant();
        logic [1:0] cv [7] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
        logic [1:0] gv [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, cv[i], cv[i], 1'b0, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL basic_sb[%0d]: got %b expected %b", i, obs, exp_v);
            end
            n_chk++;
            if (gnt !== gv[i]) begin
                n_fail++;
                $display("FAIL basic_gnt[%0d]: got %b expected %b", i, gnt, gv[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] c;
        logic       prev_valid = 1'b0;
        logic       exp_id     = 1'b0;
        int         hold       = 0;
        int         gap        = 0;
        int         n_ten      = 0;
        for (int t = 0; t < 24; t++) begin
            c = 2'b11;
            for (int i = 0; i < 2; i++) begin
                if (m_gnt[i] && hold >= 3) c[i] = 1'b0;
            end
            tick(1'b0, c, c, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rr_sb[%0d]: got %b expected %b", t, obs, exp_v);
            end
            if (gnt_valid === 1'b1) begin
                if (!prev_valid) begin
                    n_chk++;
                    if (gnt_id !== exp_id) begin
                        n_fail++;
                        $display("FAIL rr_order[%0d]: got %0d expected %0d", n_ten, gnt_id, exp_id);
                    end
                    if (n_ten > 0) begin
                        n_chk++;
                        if (gap !== 1) begin
                            n_fail++;
                            $display("FAIL rr_gap[%0d]: got %0d expected 1", n_ten, gap);
                        end
                    end
                    exp_id = ~exp_id;
                    hold   = 0;
                    n_ten++;
                end
                hold++;
                gap = 0;
            end else begin
                gap++;
            end
            prev_valid = gnt_valid;
        end
        n_chk++;
        if (n_ten < 5) begin
            n_fail++;
            $display("FAIL rr_tenures: got %0d expected at least 5", n_ten);
        end
        tick(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rr_release: got %b expected %b", obs, exp_v);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        tick(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        n_chk++;
        if (obs !== exp_v || gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL tout_grant: got %b expected %b", obs, exp_v);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL tout_sb[%0d]: got %b expected %b", i, obs, exp_v);
            end
            n++;
            if (to_err === 1'b1) break;
        end
        n_chk++;
        if (n !== 8 || slv_mask !== 1'b1) begin
            n_fail++;
            $display("FAIL tout_latency: got %0d cycles mask %b expected 8 cycles mask 1", n, slv_mask);
        end
        // Drain with acks and a competing request: both must be ignored.
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 2'b11, 2'b11, 1'b1, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if (obs !== exp_v || obs !== 6'b010101 - 6'b000000) begin
                n_fail++;
                $display("FAIL tout_drain[%0d]: got %b expected %b", i, obs, 6'b010101);
            end
        end
        tick(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        n_chk++;
        if (obs !== exp_v || obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL tout_release: got %b expected %b", obs, 6'b000000);
        end
    endtask

    task automatic test_ack_restart();
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL ack_pre[%0d]: got %b expected %b", i, obs, exp_v);
            end
        end
        tick(1'b0, 2'b01, 2'b01, 1'b1, 1'b0);
        exp_v = sb.pop_front();
        n_chk++;
        if (obs !== exp_v || to_err !== 1'b0 || slv_mask !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_wins: got %b expected %b", obs, exp_v);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL ack_post[%0d]: got %b expected %b", i, obs, exp_v);
            end
            n++;
            if (to_err === 1'b1) break;
        end
        n_chk++;
        if (n !== 8) begin
            n_fail++;
            $display("FAIL ack_restart: got %0d cycles expected 8", n);
        end
        tick(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        n_chk++;
        if (obs !== exp_v || obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL ack_release: got %b expected %b", obs, 6'b000000);
        end
    endtask

    task automatic test_release_on_threshold();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rel_pre[%0d]: got %b expected %b", i, obs, exp_v);
            end
        end
        tick(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        n_chk++;
        if (obs !== exp_v || obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL rel_wins: got %b expected %b", obs, 6'b000000);
        end
    endtask

    task automatic test_reset_in_drain();
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rd_pre[%0d]: got %b expected %b", i, obs, exp_v);
            end
        end
        n_chk++;
        if (gnt !== 2'b10 || slv_mask !== 1'b1 || to_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_in_drain: got %b expected %b", obs, 6'b101101);
        end
        tick(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        n_chk++;
        if (obs !== exp_v || obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL rd_cleared: got %b expected %b", obs, 6'b000000);
        end
        tick(1'b0, 2'b11, 2'b11, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        n_chk++;
        if (obs !== exp_v || gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL rd_m0_first: got %b expected gnt 01", obs);
        end
        tick(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rd_release: got %b expected %b", obs, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1; cyc = 2'b11; stb = 2'b11; s_ack = 1'b0; s_err = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        test_reset();
        test_basic_grant();
        test_round_robin();
        test_timeout();
        test_ack_restart();
        test_release_on_threshold();
        test_reset_in_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected completion before time limit");
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
